// File: rtl/load_store_unit.sv
// RV32I load/store unit: one access at a time through IDLE -> ISSUE -> (LDATA) -> RESP.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of force-aligning them.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_read_ready,
  output logic [29:0] mem_read_address,
  input  logic [31:0] mem_read_data,
  output logic        mem_write_ready,
  output logic [29:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_write_byte
);

  typedef enum logic [1:0] {StIdle, StIssue, StLdata, StResp} state_e;

  state_e      state_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;

  logic        funct_ok;
  logic        is_half;
  logic        is_word;
  logic        req_err;
  logic [31:0] eff_addr;
  logic [31:0] st_data;
  logic [3:0]  st_byte;

  // Select the addressed byte/half of the returned word and extend it per funct3.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lo,
                                              input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[8*lo +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'd0:    res = {{24{b[7]}}, b};
      3'd1:    res = {{16{h[15]}}, h};
      3'd2:    res = word;
      3'd4:    res = {24'b0, b};
      3'd5:    res = {16'b0, h};
      default: res = '0;
    endcase
    return res;
  endfunction

  always_comb begin
    funct_ok = req_we ? (req_funct3 <= 3'd2)
                      : !(req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7);
    is_half  = (req_funct3[1:0] == 2'b01);
    is_word  = (req_funct3[1:0] == 2'b10);
`ifdef LSU_MISALIGN_TRAP_EN
    req_err  = !funct_ok || (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
    eff_addr = req_addr;
`else
    req_err  = !funct_ok;
    eff_addr = {req_addr[31:2], req_addr[1] & ~is_word, req_addr[0] & ~(is_half | is_word)};
`endif
    // Store data is replicated across lanes so the byte enables alone pick the target.
    case (req_funct3[1:0])
      2'b00: begin
        st_data = {4{req_wdata[7:0]}};
        st_byte = 4'b0001 << eff_addr[1:0];
      end
      2'b01: begin
        st_data = {2{req_wdata[15:0]}};
        st_byte = eff_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data = req_wdata;
        st_byte = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= StIdle;
      we_q              <= 1'b0;
      funct3_q          <= '0;
      addr_lo_q         <= '0;
      req_ready         <= 1'b0;
      resp_valid        <= 1'b0;
      resp_error        <= 1'b0;
      resp_rdata        <= '0;
      mem_read_ready    <= 1'b0;
      mem_read_address  <= '0;
      mem_write_ready   <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      mem_write_byte    <= '0;
    end else begin
      mem_read_ready  <= 1'b0;
      mem_write_ready <= 1'b0;
      resp_valid      <= 1'b0;
      case (state_q)
        StIdle: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            funct3_q  <= req_funct3;
            addr_lo_q <= eff_addr[1:0];
            if (req_err) begin
              state_q    <= StResp;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state_q <= StIssue;
              if (req_we) begin
                mem_write_ready   <= 1'b1;
                mem_write_address <= eff_addr[31:2];
                mem_write_data    <= st_data;
                mem_write_byte    <= st_byte;
              end else begin
                mem_read_ready   <= 1'b1;
                mem_read_address <= eff_addr[31:2];
              end
            end
          end
        end
        StIssue: begin
          if (we_q) begin
            state_q    <= StResp;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_rdata <= '0;
          end else begin
            state_q <= StLdata;
          end
        end
        StLdata: begin
          state_q    <= StResp;
          resp_valid <= 1'b1;
          resp_error <= 1'b0;
          resp_rdata <= load_extend(mem_read_data, addr_lo_q, funct3_q);
        end
        StResp: begin
          state_q    <= StIdle;
          req_ready  <= 1'b1;
          resp_error <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array reference model, word memory responder, per-cycle compare.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_read_ready;
  logic [29:0] mem_read_address;
  logic [31:0] mem_read_data;
  logic        mem_write_ready;
  logic [29:0] mem_write_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_write_byte;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_we            (req_we),
    .req_funct3        (req_funct3),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .resp_valid        (resp_valid),
    .resp_rdata        (resp_rdata),
    .resp_error        (resp_error),
    .mem_read_ready    (mem_read_ready),
    .mem_read_address  (mem_read_address),
    .mem_read_data     (mem_read_data),
    .mem_write_ready   (mem_write_ready),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .mem_write_byte    (mem_write_byte)
  );

  typedef struct {
    int          acc;
    logic        we;
    logic        err;
    int          lat;
    logic [31:0] rdata;
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wbyte;
    logic [29:0] raddr;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_push = 0;
  int          n_resp = 0;
  int          cur_strobes = 0;
  bit          chk_en = 0;
  logic [31:0] ram [256];
  logic [7:0]  ref_bytes [1024];

  logic [29:0] last_waddr, last_raddr;
  logic [31:0] last_wdata, last_rdata;
  logic [3:0]  last_wbyte;
  logic        last_err;
  int          last_lat, last_nstrobe;

  function automatic logic [31:0] init_word(input int w);
    return (32'(w) * 32'h9E3779B1) ^ 32'hA5A55A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain byte-addressed memory, sizes 1/2/4, 10-bit aliasing like the responder.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output exp_t e);
    int size, lo;
    bit legal, mis;
    logic [31:0] eff, v;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    mis   = (a % size) != 0;
    e = '{default: '0};
    e.we = we;
`ifdef LSU_MISALIGN_TRAP_EN
    e.err = !legal || mis;
    eff   = a;
`else
    e.err = !legal;
    eff   = a - (a % size);
`endif
    e.lat = e.err ? 1 : (we ? 2 : 3);
    lo = int'(eff % 4);
    if (!e.err) begin
      if (we) begin
        e.waddr = eff[31:2];
        for (int n = 0; n < 4; n++) e.wdata[8*n +: 8] = wd[8*(n % size) +: 8];
        for (int i = 0; i < size; i++) begin
          e.wbyte[lo + i] = 1'b1;
          ref_bytes[(eff + i) & 1023] = wd[8*i +: 8];
        end
      end else begin
        e.raddr = eff[31:2];
        v = '0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = ref_bytes[(eff + i) & 1023];
        if (size < 4 && !f3[2] && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
        e.rdata = v;
      end
    end
  endtask

  // Memory responder: read data appears the cycle after the strobe is sampled.
  initial begin
    for (int w = 0; w < 256; w++) ram[w] = init_word(w);
    mem_read_data = '0;
    forever begin
      @(posedge clk);
      if (mem_write_ready)
        for (int n = 0; n < 4; n++)
          if (mem_write_byte[n]) ram[mem_write_address[7:0]][8*n +: 8] = mem_write_data[8*n +: 8];
      if (mem_read_ready) mem_read_data <= ram[mem_read_address[7:0]];
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Compare process: req_ready, strobes and responses checked against the expectation queue.
  initial begin
    bit pend;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        pend = (q.size() > 0) && (cyc > q[0].acc);
        chk("req_ready", {31'b0, req_ready}, {31'b0, !pend});
        if (mem_read_ready || mem_write_ready) begin
          if (!pend) chk("unexpected_strobe", {30'b0, mem_write_ready, mem_read_ready}, 32'd0);
          else begin
            chk("strobe_cycle", cyc, q[0].acc + 1);
            chk("strobe_kind", {30'b0, mem_write_ready, mem_read_ready},
                q[0].we ? 32'd2 : 32'd1);
            if (mem_write_ready) begin
              chk("waddr", {2'b0, mem_write_address}, {2'b0, q[0].waddr});
              chk("wdata", mem_write_data, q[0].wdata);
              chk("wbyte", {28'b0, mem_write_byte}, {28'b0, q[0].wbyte});
              last_waddr = mem_write_address;
              last_wdata = mem_write_data;
              last_wbyte = mem_write_byte;
            end else begin
              chk("raddr", {2'b0, mem_read_address}, {2'b0, q[0].raddr});
              last_raddr = mem_read_address;
            end
            cur_strobes++;
          end
        end
        if (resp_valid) begin
          if (!pend) chk("unexpected_resp", {31'b0, resp_valid}, 32'd0);
          else begin
            chk("latency", cyc - q[0].acc, q[0].lat);
            chk("resp_error", {31'b0, resp_error}, {31'b0, q[0].err});
            chk("resp_rdata", resp_rdata, q[0].rdata);
            chk("strobe_count", cur_strobes, q[0].err ? 0 : 1);
            last_lat     = cyc - q[0].acc;
            last_err     = resp_error;
            last_rdata   = resp_rdata;
            last_nstrobe = cur_strobes;
            cur_strobes  = 0;
            n_resp++;
            void'(q.pop_front());
          end
        end else if (pend && cyc > q[0].acc + q[0].lat) begin
          chk("resp_timeout", {31'b0, resp_valid}, 32'd1);
          cur_strobes = 0;
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd);
    exp_t e;
    int t;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      chk("accept_timeout", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    model(we, f3, a, wd, e);
    e.acc = cyc;
    q.push_back(e);
    n_push++;
    @(posedge clk);
  endtask

  task automatic wait_done();
    int t;
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 32'd0);
    @(negedge clk);
  endtask

  task automatic check_reset_values();
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp", {30'b0, resp_valid, resp_error}, 32'd0);
    chk("rst_strobes", {30'b0, mem_read_ready, mem_write_ready}, 32'd0);
    chk("rst_wbyte", {28'b0, mem_write_byte}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_addrs", {2'b0, mem_read_address | mem_write_address}, 32'd0);
    chk("rst_wdata", mem_write_data, 32'd0);
  endtask

  task automatic check_release();
    chk("rel_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rel_strobes", {30'b0, mem_read_ready, mem_write_ready}, 32'd0);
    chk("rel_resp_valid", {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = '0;
    req_addr = '0;
    req_wdata = '0;
    for (int w = 0; w < 256; w++) begin
      logic [31:0] iw;
      iw = init_word(w);
      for (int i = 0; i < 4; i++) ref_bytes[4*w + i] = iw[8*i +: 8];
    end

    repeat (3) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    @(negedge clk);
    check_release();
    chk_en = 1;

    send(1'b1, 3'd2, 32'h104, 32'hDEADBEEF);
    wait_done();
    chk("sw_waddr", {2'b0, last_waddr}, 32'h41);
    chk("sw_wbyte", {28'b0, last_wbyte}, 32'hF);
    chk("sw_wdata", last_wdata, 32'hDEADBEEF);
    chk("sw_lat", last_lat, 2);

    send(1'b1, 3'd2, 32'h100, 32'h12345678);
    send(1'b1, 3'd0, 32'h103, 32'h0000005A);
    wait_done();
    chk("sb_wbyte", {28'b0, last_wbyte}, 32'h8);
    chk("sb_wdata", last_wdata, 32'h5A5A5A5A);
    send(1'b0, 3'd0, 32'h103, 32'h0);
    wait_done();
    chk("lb_5a", last_rdata, 32'h0000005A);
    send(1'b1, 3'd0, 32'h103, 32'h00000080);
    send(1'b0, 3'd4, 32'h103, 32'h0);
    wait_done();
    chk("lbu_80", last_rdata, 32'h00000080);
    send(1'b0, 3'd0, 32'h103, 32'h0);
    wait_done();
    chk("lb_80", last_rdata, 32'hFFFFFF80);

    send(1'b1, 3'd2, 32'h200, 32'h80017FFF);
    send(1'b0, 3'd1, 32'h202, 32'h0);
    wait_done();
    chk("lh_202", last_rdata, 32'hFFFF8001);
    chk("lh_lat", last_lat, 3);
    send(1'b0, 3'd5, 32'h200, 32'h0);
    wait_done();
    chk("lhu_200", last_rdata, 32'h00007FFF);

    send(1'b0, 3'd2, 32'h102, 32'h0);
    wait_done();
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_mis_err", {31'b0, last_err}, 32'd1);
    chk("lw_mis_lat", last_lat, 1);
    chk("lw_mis_strobes", last_nstrobe, 0);
`else
    chk("lw_mis_rdata", last_rdata, 32'h80345678);
    chk("lw_mis_raddr", {2'b0, last_raddr}, 32'h40);
`endif

    send(1'b0, 3'd3, 32'h10, 32'h0);
    wait_done();
    chk("f3_illegal_err", {31'b0, last_err}, 32'd1);
    chk("f3_illegal_rdata", last_rdata, 32'd0);
    chk("f3_illegal_strobes", last_nstrobe, 0);
    chk("f3_illegal_lat", last_lat, 1);

    // Abandon a load in its ISSUE cycle.
    send(1'b0, 3'd2, 32'h300, 32'h0);
    @(negedge clk);
    chk_en = 0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    q.delete();
    cur_strobes = 0;
    n_push--;
    @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    @(negedge clk);
    check_release();
    chk_en = 1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(3, 7));
      else if (we) f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
      end
      a = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_FC00);
      send(we, f3, a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        req_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    wait_done();
    chk("resp_count", n_resp, n_push);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port req_valid, input, 1 bit: pipeline presents an access.
REQ-004 SHALL have port req_ready, output, 1 bit: unit accepts; transfer when req_valid && req_ready.
REQ-005 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port req_funct3, input, 3 bits: RV32I size/sign (0 B, 1 H, 2 W, 4 BU, 5 HU).
REQ-007 SHALL have port req_addr, input, 32 bits: byte address.
REQ-008 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-009 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port resp_rdata, output, 32 bits: extended load result; 0 for stores and errors.
REQ-011 SHALL have port resp_error, output, 1 bit: misaligned or illegal funct3; qualified by resp_valid.
REQ-012 SHALL have port mem_read_ready, output, 1 bit: memory read strobe.
REQ-013 SHALL have port mem_read_address, output, 30 bits [31:2]: word read address.
REQ-014 SHALL have port mem_read_data, input, 32 bits: valid the cycle after the sampling edge of mem_read_ready.
REQ-015 SHALL have port mem_write_ready, output, 1 bit: memory write strobe.
REQ-016 SHALL have port mem_write_address, output, 30 bits [31:2]: word write address.
REQ-017 SHALL have port mem_write_data, output, 32 bits: lane-replicated store data.
REQ-018 SHALL have port mem_write_byte, output, 4 bits: byte-lane enables, bit n = bits 8n+7:8n.

Function
REQ-019 SHALL implement states IDLE, ISSUE, LDATA, RESP; req_ready=1 only in IDLE.
REQ-020 On accept in IDLE, SHALL register we/funct3/addr/wdata and go to ISSUE, or to RESP with error flag if the request is illegal.
REQ-021 In ISSUE, SHALL drive exactly one strobe (mem_read_ready or mem_write_ready) for one cycle; loads -> LDATA, stores -> RESP.
REQ-022 In LDATA, SHALL capture mem_read_data, select/extend it into resp_rdata, and go to RESP.
REQ-023 In RESP, SHALL assert resp_valid for exactly one cycle, then return to IDLE; no back-to-back accept in RESP.
REQ-024 Latency from accept edge to resp_valid cycle SHALL be: store 2 cycles, load 3, error 1.
REQ-025 Store lanes: SB data {4{wdata[7:0]}}, byte 1<<addr[1:0]; SH {2{wdata[15:0]}}, byte 0011 (addr[1]=0) or 1100; SW wdata, 1111.
REQ-026 Loads SHALL select the byte/half at addr[1:0]/addr[1]; B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through.
REQ-027 Illegal funct3 SHALL be: loads 3, 6, 7; stores 3-7; error response, no memory strobe.
REQ-028 Strobes SHALL be 0 in every state except ISSUE; unused address/data outputs hold their last values.

Reset
REQ-029 While rst_n=0 at a rising edge, SHALL enter IDLE, with req_ready, resp_valid, resp_error, mem_read_ready, mem_write_ready and mem_write_byte at 0, resp_rdata, mem_read_address, mem_write_address and mem_write_data at 0, and the registered request cleared.
REQ-030 Reset in any state SHALL abandon the access, with no strobe and no resp_valid in the first cycle after release; req_ready=1 from that cycle.

Configuration
REQ-031 Macro LSU_MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 SHALL give an error response (1-cycle latency) with no strobe.
REQ-032 Macro LSU_MISALIGN_TRAP_EN undefined: misaligned H SHALL clear addr[0] and W SHALL clear addr[1:0], then proceed normally; resp_error only for illegal funct3.

Verification
REQ-033 SW addr 0x104, wdata 0xDEADBEEF -> ISSUE cycle: mem_write_address=0x41, byte 1111, data 0xDEADBEEF; resp_valid 2 cycles after accept.
REQ-034 SB addr 0x103, wdata 0x5A, then LB 0x103 -> byte 1000, data 0x5A5A5A5A; load resp_rdata 0x0000005A; LBU of 0x80 stored -> 0x00000080, LB -> 0xFFFFFF80.
REQ-035 Memory word 0x8001_7FFF at 0x200: LH 0x202 -> 0xFFFF8001; LHU 0x200 -> 0x00007FFF; resp_valid 3 cycles after accept.
REQ-036 LW 0x102 -> with macro: resp_error=1 after 1 cycle, no strobe; without: reads word 0x100.
REQ-037 Load funct3=3 -> resp_error=1, resp_rdata=0, no strobe; rst_n=0 during ISSUE -> no strobe and no resp_valid after release, req_ready=1.
REQ-038 req_valid held high continuously -> one accept per response; req_ready low from accept through the RESP cycle.
